// File: rtl/apb_master_ctrl_pkg.sv
// apb_pkg: shared types and default parameters for the APB master sequencer.
//   state_t        - sequencer states (IDLE, SETUP, ACCESS, DONE)
//   ID1_DEF        - default sel value that targets APB bus 1
//   ID2_DEF        - default sel value that targets APB bus 2
//   IDLE_SEL_DEF   - sel value driven on a bus that is not being accessed
//   TIMEOUT_DEF    - default ACCESS-cycle budget before a timeout error
package apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ID1_DEF      = 2'b01;
  localparam logic [1:0] ID2_DEF      = 2'b10;
  localparam logic [1:0] IDLE_SEL_DEF = 2'b00;
  localparam int         TIMEOUT_DEF  = 64;

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: clear/enable saturating counter with terminal count.
// Width is clog2(TIMEOUT); the count stops at TIMEOUT-1, where tc is high.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-low reset
//   clr    in  synchronous clear (wins over en)
//   en     in  count enable
//   tc     out count == TIMEOUT-1
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset)         count <= '0;
    else if (clr)       count <= '0;
    else if (en && !tc) count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB master sequencer. Takes one processor transaction at a
// time, routes it by target ID to APB bus 1 or bus 2, runs SETUP/ACCESS with a
// bounded wait for ready, then returns read data plus a one-cycle completion
// (and optional error) pulse.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   p_start/p_write/p_sel/...  processor request (sampled in IDLE only)
//   p_rdata/p_stable/p_error   processor response (pulse in DONE)
//   busy                       high from accept until DONE is left
//   m_write/m_addr/m_wdata/m_wait_cycles  broadcast to both buses
//   apbN_sel/apbN_enable       per-bus select and enable
//   apbN_ready/apbN_rdata      per-bus slave response
// All outputs are registered.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter logic [1:0] ID1      = ID1_DEF,
  parameter logic [1:0] ID2      = ID2_DEF,
  parameter logic [1:0] IDLE_SEL = IDLE_SEL_DEF,
  parameter int         TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_start,
  input  logic       p_write,
  input  logic [1:0] p_sel,
  input  logic [7:0] p_addr,
  input  logic [7:0] p_wdata,
  input  logic [7:0] p_wait_cycles,
  output logic [7:0] p_rdata,
  output logic       p_stable,
  output logic       p_error,
  output logic       busy,
  output logic       m_write,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  output logic [7:0] m_wait_cycles,
  output logic [1:0] apb1_sel,
  output logic       apb1_enable,
  input  logic       apb1_ready,
  input  logic [7:0] apb1_rdata,
  output logic [1:0] apb2_sel,
  output logic       apb2_enable,
  input  logic       apb2_ready,
  input  logic [7:0] apb2_rdata
);

  state_t state;
  logic   tgt2;       // 1 = current transfer targets bus 2
  logic   sel_ready;
  logic [7:0] sel_rdata;
  logic   tc;

  // Only the targeted bus's response is looked at; the other is ignored.
  assign sel_ready = tgt2 ? apb2_ready : apb1_ready;
  assign sel_rdata = tgt2 ? apb2_rdata : apb1_rdata;

  // Counter is held clear outside ACCESS, so it starts at 0 on the first
  // ACCESS cycle and tc marks the TIMEOUT-th ACCESS cycle without ready.
  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (state != S_ACCESS),
    .en    (state == S_ACCESS && !sel_ready),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      tgt2          <= 1'b0;
      p_rdata       <= '0;
      p_stable      <= 1'b0;
      p_error       <= 1'b0;
      busy          <= 1'b0;
      m_write       <= 1'b0;
      m_addr        <= '0;
      m_wdata       <= '0;
      m_wait_cycles <= '0;
      apb1_sel      <= IDLE_SEL;
      apb1_enable   <= 1'b0;
      apb2_sel      <= IDLE_SEL;
      apb2_enable   <= 1'b0;
    end else begin
      // Completion flags live for exactly the DONE cycle.
      p_stable <= 1'b0;
      p_error  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p_start) begin
            m_write       <= p_write;
            m_addr        <= p_addr;
            m_wdata       <= p_wdata;
            m_wait_cycles <= p_wait_cycles;
            if (p_sel == ID1) begin
              apb1_sel <= p_sel;
              tgt2     <= 1'b0;
              busy     <= 1'b1;
              state    <= S_SETUP;
            end else if (p_sel == ID2) begin
              apb2_sel <= p_sel;
              tgt2     <= 1'b1;
              busy     <= 1'b1;
              state    <= S_SETUP;
            end else begin
              // Unknown target: report an error without touching either bus.
              p_stable <= 1'b1;
              p_error  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_SETUP: begin
          if (tgt2) apb2_enable <= 1'b1;
          else      apb1_enable <= 1'b1;
          state <= S_ACCESS;
        end
        S_ACCESS: begin
          // Ready on the terminal-count cycle is still a success.
          if (sel_ready || tc) begin
            if (sel_ready && !m_write) p_rdata <= sel_rdata;
            apb1_sel    <= IDLE_SEL;
            apb2_sel    <= IDLE_SEL;
            apb1_enable <= 1'b0;
            apb2_enable <= 1'b0;
            p_stable    <= 1'b1;
            p_error     <= !sel_ready;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: randomized transfers checked
// cycle-by-cycle against a transaction-level expectation (ready delay ->
// completion cycle, error, read data).
module tb_apb_master_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       p_start, p_write;
  logic [1:0] p_sel;
  logic [7:0] p_addr, p_wdata, p_wait_cycles;
  logic [7:0] p_rdata;
  logic       p_stable, p_error, busy;
  logic       m_write;
  logic [7:0] m_addr, m_wdata, m_wait_cycles;
  logic [1:0] apb1_sel, apb2_sel;
  logic       apb1_enable, apb2_enable;
  logic       apb1_ready, apb2_ready;
  logic [7:0] apb1_rdata, apb2_rdata;

  apb_master_ctrl dut (
    .clk(clk), .reset(reset),
    .p_start(p_start), .p_write(p_write), .p_sel(p_sel), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_wait_cycles(p_wait_cycles),
    .p_rdata(p_rdata), .p_stable(p_stable), .p_error(p_error), .busy(busy),
    .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wait_cycles(m_wait_cycles),
    .apb1_sel(apb1_sel), .apb1_enable(apb1_enable), .apb1_ready(apb1_ready),
    .apb1_rdata(apb1_rdata),
    .apb2_sel(apb2_sel), .apb2_enable(apb2_enable), .apb2_ready(apb2_ready),
    .apb2_rdata(apb2_rdata)
  );

  always #5 clk = ~clk;

  localparam int TMO = 64;

  int errors = 0;
  int checks = 0;
  logic [7:0] mdl_rdata = 8'h00;  // last read data the processor should see

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_p();
    p_write       = 1'($urandom);
    p_sel         = 2'($urandom);
    p_addr        = 8'($urandom);
    p_wdata       = 8'($urandom);
    p_wait_cycles = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".stable"}, p_stable, 0);
    chk({tag, ".error"},  p_error, 0);
    chk({tag, ".busy"},   busy, 0);
    chk({tag, ".rdata"},  p_rdata, 0);
    chk({tag, ".m_bus"},  {m_write, m_addr, m_wdata, m_wait_cycles}, 0);
    chk({tag, ".sel"},    {apb1_sel, apb2_sel}, 0);
    chk({tag, ".en"},     {apb1_enable, apb2_enable}, 0);
  endtask

  // One transfer to bus `bus` (1/2); the slave raises ready after `d` ACCESS
  // cycles. d >= TMO means it never answers in time. Entered and left in IDLE.
  task automatic run_xfer(input bit wr, input int bus, input int d, input bit poke);
    logic [7:0] a  = 8'($urandom);
    logic [7:0] w  = 8'($urandom);
    logic [7:0] wc = 8'($urandom);
    logic [7:0] rd = 8'($urandom);
    logic [1:0] id = (bus == 1) ? 2'b01 : 2'b10;
    bit   tmo      = (d >= TMO);
    int   done_k   = tmo ? 2 + TMO : 3 + d;
    int   poke_k   = poke ? $urandom_range(2, done_k) : -1;
    logic [1:0] s_t, s_o;
    logic e_t, e_o, rdy;
    p_start = 1'b1; p_write = wr; p_sel = id;
    p_addr = a; p_wdata = w; p_wait_cycles = wc;
    apb1_ready = 1'b0; apb2_ready = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      step();
      p_start = 1'b0;
      scramble_p();
      s_t = (bus == 1) ? apb1_sel : apb2_sel;
      s_o = (bus == 1) ? apb2_sel : apb1_sel;
      e_t = (bus == 1) ? apb1_enable : apb2_enable;
      e_o = (bus == 1) ? apb2_enable : apb1_enable;
      if (k < done_k) begin
        chk("xfer.sel", s_t, id);
        chk("xfer.other_sel", s_o, 0);
        chk("xfer.en", e_t, (k >= 2));
        chk("xfer.other_en", e_o, 0);
        chk("xfer.stable", p_stable, 0);
        chk("xfer.busy", busy, 1);
        chk("xfer.m_bus", {m_write, m_addr, m_wdata, m_wait_cycles}, {wr, a, w, wc});
      end else if (k == done_k) begin
        chk("done.sel", {apb1_sel, apb2_sel}, 0);
        chk("done.en", {apb1_enable, apb2_enable}, 0);
        chk("done.stable", p_stable, 1);
        chk("done.error", p_error, tmo);
        chk("done.busy", busy, 1);
        if (!wr && !tmo) mdl_rdata = rd;
        chk("done.rdata", p_rdata, mdl_rdata);
      end else begin
        chk("idle.stable", p_stable, 0);
        chk("idle.busy", busy, 0);
        chk("idle.sel", {apb1_sel, apb2_sel}, 0);
      end
      // Inputs for cycle k: target ready follows the slave delay, other bus noise.
      rdy = (k >= 2) && (k - 2 >= d);
      if (k == poke_k) p_start = 1'b1;
      if (bus == 1) begin
        apb1_ready = rdy; apb1_rdata = rdy ? rd : 8'($urandom);
        apb2_ready = 1'($urandom); apb2_rdata = 8'($urandom);
      end else begin
        apb2_ready = rdy; apb2_rdata = rdy ? rd : 8'($urandom);
        apb1_ready = 1'($urandom); apb1_rdata = 8'($urandom);
      end
    end
    p_start = 1'b0; apb1_ready = 1'b0; apb2_ready = 1'b0;
  endtask

  task automatic run_bad_id(input logic [1:0] id);
    logic [7:0] a = 8'($urandom);
    p_start = 1'b1; p_sel = id; p_addr = a; p_write = 1'($urandom);
    apb1_ready = 1'($urandom); apb2_ready = 1'($urandom);
    step();
    p_start = 1'b0; scramble_p();
    chk("bad.stable", p_stable, 1);
    chk("bad.error", p_error, 1);
    chk("bad.sel", {apb1_sel, apb2_sel}, 0);
    chk("bad.en", {apb1_enable, apb2_enable}, 0);
    chk("bad.rdata", p_rdata, mdl_rdata);
    chk("bad.m_addr", m_addr, a);
    step();
    chk("bad.after_stable", p_stable, 0);
    chk("bad.after_sel", {apb1_sel, apb2_sel, apb1_enable, apb2_enable}, 0);
    apb1_ready = 1'b0; apb2_ready = 1'b0;
  endtask

  task automatic run_reset_abort(input int bus);
    int seen = 0;
    p_start = 1'b1; p_write = 1'b0; p_sel = (bus == 1) ? 2'b01 : 2'b10;
    p_addr = 8'($urandom);
    apb1_ready = 1'b0; apb2_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      p_start = 1'b0;
    end
    chk("abort.pre_en", apb1_enable | apb2_enable, 1);
    reset = 1'b0;
    step();
    chk_reset_outputs("abort");
    mdl_rdata = 8'h00;
    reset = 1'b1;
    // Slave answers now; nothing may complete for the dropped transfer.
    apb1_ready = 1'b1; apb2_ready = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      if (p_stable) seen++;
    end
    chk("abort.no_stable", seen, 0);
    apb1_ready = 1'b0; apb2_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; p_start = 1'b0;
    p_write = 1'b0; p_sel = 2'b00; p_addr = '0; p_wdata = '0; p_wait_cycles = '0;
    apb1_ready = 1'b0; apb2_ready = 1'b0; apb1_rdata = '0; apb2_rdata = '0;
    step(); step();
    chk_reset_outputs("reset");
    reset = 1'b1;
    step();

    run_xfer(1'b1, 1, 0, 1'b0);      // zero-wait write, bus 1
    run_xfer(1'b0, 2, 5, 1'b0);      // read bus 2 after 5 waits
    run_xfer(1'b0, 1, 100, 1'b0);    // timeout
    run_xfer(1'b0, 2, TMO - 1, 1'b0);// ready on last allowed cycle
    run_xfer(1'b0, 1, TMO - 2, 1'b0);
    run_xfer(1'b1, 2, TMO, 1'b0);    // ready one cycle too late
    run_bad_id(2'b11);
    run_bad_id(2'b00);
    run_xfer(1'b0, 1, 4, 1'b1);      // p_start poked mid-transfer
    run_xfer(1'b0, 2, 0, 1'b0);      // back-to-back

    for (int t = 0; t < 30; t++) begin
      int d;
      if ($urandom_range(0, 9) == 0) begin
        run_bad_id(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
      end else begin
        d = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 3, TMO + 3)
                                        : $urandom_range(0, 8);
        run_xfer(1'($urandom), $urandom_range(1, 2), d, 1'($urandom));
      end
    end

    run_reset_abort(2);
    run_xfer(1'b0, 1, 2, 1'b0);      // recovers after abort

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
